// File: rtl/sa_array_sequencer.sv
// Control sequencer for the output-stationary transposed-convolution systolic array:
// one tile runs as clear, skewed compute wavefront, row-by-row eject, then a done pulse.
module sa_array_sequencer #(
  parameter  int DIMENSION = 16,
  parameter  int CW        = 10,
  localparam int PES       = DIMENSION * DIMENSION,
  localparam int RW        = $clog2(DIMENSION)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    num_steps,
  input  logic [DIMENSION-1:0] sel_cfg,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic [PES-1:0]   en_in,
  output logic [PES-1:0]   en_psum,
  output logic [PES-1:0]   en_out,
  output logic [PES-1:0]   clear_psum,
  output logic [DIMENSION-1:0] ifmaps_sel,
  output logic [DIMENSION-1:0] output_eject_ctrl,
  output logic             in_ready,
  output logic             out_valid,
  output logic [RW-1:0]    out_row_idx,
  output logic             busy,
  output logic             done
);

  localparam int CW1 = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_EJECT,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [CW-1:0]        num_q;
  logic [DIMENSION-1:0] sel_q;
  logic [CW-1:0]        step_cnt;
  logic [RW-1:0]        beat_cnt;
  logic [CW-1:0]        last_step;
  logic [PES-1:0]       wave;

  // The last accepted step is the one where the far corner PE finishes its window.
  assign last_step = num_q + CW'(2 * (DIMENSION - 1) - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q    <= '0;
      sel_q    <= '0;
      step_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_q    <= num_steps;
            sel_q    <= sel_cfg;
            step_cnt <= '0;
            beat_cnt <= '0;
          end
        end
        S_COMPUTE: if (in_valid) step_cnt <= step_cnt + CW'(1);
        S_EJECT:   if (out_ready) beat_cnt <= beat_cnt + RW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_CLEAR;
      S_CLEAR:   state_n = (num_q != '0) ? S_COMPUTE : S_EJECT;
      S_COMPUTE: if (in_valid && step_cnt == last_step) state_n = S_EJECT;
      S_EJECT:   if (out_ready && beat_cnt == RW'(DIMENSION - 1)) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // PE(i,j) is inside its MAC window while i+j <= step < i+j+num_steps.
  always_comb begin
    logic [CW:0] lo;
    lo   = '0;
    wave = '0;
    for (int i = 0; i < DIMENSION; i++) begin
      for (int j = 0; j < DIMENSION; j++) begin
        lo = CW1'(i + j);
        wave[i*DIMENSION+j] = ({1'b0, step_cnt} >= lo) &&
                              ({1'b0, step_cnt} < lo + {1'b0, num_q});
      end
    end
  end

  always_comb begin
    en_in             = '0;
    en_psum           = '0;
    en_out            = '0;
    clear_psum        = '0;
    ifmaps_sel        = '0;
    output_eject_ctrl = '0;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    out_row_idx       = '0;
    busy              = (state != S_IDLE);
    done              = 1'b0;
    case (state)
      S_CLEAR: clear_psum = '1;
      S_COMPUTE: begin
        in_ready   = 1'b1;
        ifmaps_sel = sel_q;
        if (in_valid) begin
          en_in   = wave;
          en_psum = wave;
        end
      end
      S_EJECT: begin
        output_eject_ctrl = '1;
        out_valid         = 1'b1;
        out_row_idx       = beat_cnt;
        if (out_ready) en_out = '1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sa_array_sequencer.sv
// Bench for sa_array_sequencer (DIMENSION=4): directed tiles plus random stall traffic,
// compared every cycle against a count-based model of the tile schedule.
module tb_sa_array_sequencer;

  localparam int D  = 4;
  localparam int N  = D * D;
  localparam int CW = 10;
  localparam int RW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_steps = '0;
  logic [D-1:0]  sel_cfg = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  en_in, en_psum, en_out, clear_psum;
  logic [D-1:0]  ifmaps_sel, output_eject_ctrl;
  logic          in_ready, out_valid, busy, done;
  logic [RW-1:0] out_row_idx;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a tile is described only by how many steps and beats were accepted.
  bit           m_tile = 0;
  bit           m_cleared = 0;
  int           m_n = 0;
  int           m_acc = 0;
  int           m_beats = 0;
  logic [D-1:0] m_sel = '0;

  sa_array_sequencer #(.DIMENSION(D), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .sel_cfg(sel_cfg),
    .in_valid(in_valid), .out_ready(out_ready), .en_in(en_in), .en_psum(en_psum),
    .en_out(en_out), .clear_psum(clear_psum), .ifmaps_sel(ifmaps_sel),
    .output_eject_ctrl(output_eject_ctrl), .in_ready(in_ready), .out_valid(out_valid),
    .out_row_idx(out_row_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // 0 idle, 1 clear, 2 compute, 3 eject, 4 done
  function automatic int phase();
    int total;
    total = (m_n == 0) ? 0 : m_n + 2 * D - 2;
    if (!m_tile) return 0;
    if (!m_cleared) return 1;
    if (m_acc < total) return 2;
    if (m_beats < D) return 3;
    return 4;
  endfunction

  function automatic logic [N-1:0] wave_exp(input int acc, input int n);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        v[i*D+j] = (acc >= i + j) && (acc < i + j + n);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [CW-1:0] n, input logic [D-1:0] sel,
                               input logic iv, input logic ordy);
    start     = st;
    num_steps = n;
    sel_cfg   = sel;
    in_valid  = iv;
    out_ready = ordy;
  endtask

  task automatic checkOutput();
    int           ph;
    logic [N-1:0] e_en;
    ph   = phase();
    e_en = (ph == 2 && in_valid) ? wave_exp(m_acc, m_n) : '0;
    chk("en_in",      64'(en_in),      64'(e_en));
    chk("en_psum",    64'(en_psum),    64'(e_en));
    chk("en_out",     64'(en_out),     64'((ph == 3 && out_ready) ? {N{1'b1}} : {N{1'b0}}));
    chk("clear_psum", 64'(clear_psum), 64'((ph == 1) ? {N{1'b1}} : {N{1'b0}}));
    chk("ifmaps_sel", 64'(ifmaps_sel), 64'((ph == 2) ? m_sel : {D{1'b0}}));
    chk("eject_ctrl", 64'(output_eject_ctrl), 64'((ph == 3) ? {D{1'b1}} : {D{1'b0}}));
    chk("in_ready",   64'(in_ready),   64'(ph == 2));
    chk("out_valid",  64'(out_valid),  64'(ph == 3));
    chk("out_row_idx", 64'(out_row_idx), 64'((ph == 3) ? m_beats : 0));
    chk("busy",       64'(busy),       64'(ph != 0));
    chk("done",       64'(done),       64'(ph == 4));
  endtask

  task automatic modelUpdate();
    case (phase())
      0: if (start) begin
        m_tile    = 1;
        m_cleared = 0;
        m_n       = int'(num_steps);
        m_sel     = sel_cfg;
        m_acc     = 0;
        m_beats   = 0;
      end
      1: m_cleared = 1;
      2: if (in_valid) m_acc++;
      3: if (out_ready) m_beats++;
      default: m_tile = 0;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic asyncReset();
    #1 rst = 1'b1;
    #1 m_tile = 0;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // mode: 0 clean, 1 in_valid stall, 2 out_ready stall, 3 random, 4 start held, 5 reset at s=5
  task automatic runTile(input int n, input logic [D-1:0] sel, input int mode, input int exp_lat);
    int   stalls = 0, lat = -1, hold = 0, ph, want;
    bit   aborted = 0;
    logic st, iv, ordy;
    logic [CW-1:0] nn;
    logic [D-1:0]  ss;
    applyStimulus(1'b1, CW'(n), sel, 1'b1, 1'b1);
    step();
    for (int t = 1; t <= 400; t++) begin
      ph = phase();
      if (mode == 5 && ph == 2 && m_acc == 5) begin
        asyncReset();
        aborted = 1;
        break;
      end
      st = (mode == 4); iv = 1'b1; ordy = 1'b1; nn = CW'(n); ss = sel;
      if (mode == 1 && ph == 2 && m_acc == 4 && hold < 2) begin iv = 1'b0; hold++; end
      if (mode == 2 && ph == 3 && m_beats == 1 && hold < 3) begin ordy = 1'b0; hold++; end
      if (mode == 3) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        st   = 1'($urandom_range(0, 1));
        ss   = D'($urandom);
      end
      if (mode >= 3) nn = CW'($urandom_range(0, 9));
      if (ph == 2 && !iv) stalls++;
      if (ph == 3 && !ordy) stalls++;
      if (ph == 4) lat = t;
      applyStimulus(st, nn, ss, iv, ordy);
      step();
      if (lat >= 0 && !m_tile) break;
    end
    if (aborted) begin
      chk("abort_no_done", 64'(lat < 0), 64'(1));
    end else begin
      want = (exp_lat >= 0) ? exp_lat : 1 + ((n > 0) ? n + 2 * D - 2 : 0) + D + 1 + stalls;
      chk("latency", 64'(lat), 64'(want));
    end
  endtask

  initial begin
    $display("[TB] start");
    #1 rst = 1'b1;
    #2 checkOutput();
    #9 rst = 1'b0;
    @(posedge clk);
    #1;
    runTile(3, 4'b0110, 0, 15);
    runTile(3, 4'b0011, 1, 17);
    runTile(3, 4'b1100, 2, 18);
    runTile(0, 4'b1111, 0, 6);
    runTile(3, 4'b0101, 5, -1);
    runTile(3, 4'b1001, 0, 15);
    runTile(2, 4'b1010, 4, -1);
    runTile(5, 4'b1010, 4, -1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 8; k++)
      runTile($urandom_range(0, 6), D'($urandom), 3, -1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
